pipe_stage_reg: RTL

Parametrised inter-stage pipeline register for the 5-stage MIPS CPU with CP0 support. It generalises the fixed-field stage registers: a configurable payload width, a configurable Tnew width with optional saturating decrement, and a stage-local exception merge. It has four control modes: load, hold (stall), bubble-with-PC-retain (flush), and interrupt/exception trap-flush. It is instantiated between any two stages (D/E, E/M, M/W) and feeds the hazard unit (Tnew, A3, RFWr) and CP0 (PC, BD, ExcCode).

---
 rtl/pipe_stage_reg_if.sv | 38 +++
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
//   Field bundle carried between two pipeline stages of the MIPS core.
//   One instance feeds a stage register (slave side) and another carries the
//   registered copy onward (master side).
//
//   valid    slot holds a real instruction
//   instr    instruction word
//   pc       instruction PC
//   payload  opaque stage data (PAYLOAD_W bits)
//   a3       destination register number
//   rfwr     register-file write enable
//   tnew     cycles until the result is available (TNEW_W bits)
//   exc      ExcCode, 0 = no exception
//   bd       instruction sits in a branch delay slot
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
   parameter int PAYLOAD_W = 64,
   parameter int TNEW_W    = 2
);
   logic                 valid;
   logic [31:0]          instr;
   logic [31:0]          pc;
   logic [PAYLOAD_W-1:0] payload;
   logic [4:0]           a3;
   logic                 rfwr;
   logic [TNEW_W-1:0]    tnew;
   logic [4:0]           exc;
   logic                 bd;

   modport master (
      output valid, instr, pc, payload, a3, rfwr, tnew, exc, bd
   );

   modport slave (
      input valid, instr, pc, payload, a3, rfwr, tnew, exc, bd
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic inter-stage register for the 5-stage MIPS pipeline with CP0.
//   Sits between D/E, E/M or M/W and feeds the hazard unit (tnew, a3, rfwr)
//   and CP0 (pc, bd, exc).  All outputs are registered; there is no
//   combinational path from any input to any output.
//
//   Control priority on each edge: req > flush > stall > load.
//     req   : trap-flush, slot emptied and pc forced to TRAP_PC
//     flush : bubble, slot emptied but pc/bd kept so CP0 still sees a valid
//             EPC/BD if an interrupt lands while the bubble is in this stage
//     stall : every field holds (tnew is not decremented while held)
//     load  : fields copied from src, tnew optionally decremented, exception
//             merged with the one detected in the upstream stage
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high
//   stall      hold all stage state
//   flush      insert a bubble, keep pc/bd
//   req        interrupt/exception trap-flush
//   local_exc  ExcCode raised by the upstream stage itself
//   src        incoming stage fields (slave modport)
//   dst        registered stage fields (master modport)
//   stall_cnt  saturating count of edges with stall=1 and req=0
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int          PAYLOAD_W = 64,
   parameter int          TNEW_W    = 2,
   parameter bit          DEC_TNEW  = 1'b1,
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] TRAP_PC   = 32'h0000_4180,
   parameter int          CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  req,
   input  logic [4:0]            local_exc,
   pipe_stage_reg_if.slave       src,
   pipe_stage_reg_if.master      dst,
   output logic [CNT_W-1:0]      stall_cnt
);

   // registered fields
   logic                 valid_q;
   logic [31:0]          instr_q;
   logic [31:0]          pc_q;
   logic [PAYLOAD_W-1:0] payload_q;
   logic [4:0]           a3_q;
   logic                 rfwr_q;
   logic [TNEW_W-1:0]    tnew_q;
   logic [4:0]           exc_q;
   logic                 bd_q;
   logic [CNT_W-1:0]     cnt_q;

   // values presented on a plain load
   logic [TNEW_W-1:0]    tnew_load;
   logic [4:0]           exc_load;

   // Tnew ageing: one stage further down the pipe means one cycle closer to
   // the result being ready.  Saturate at zero so a finished producer never
   // wraps back to "not ready".
   generate
      if (DEC_TNEW) begin : g_tnew_dec
         always_comb begin
            tnew_load = '0;
            if (src.tnew != '0) begin
               tnew_load = src.tnew - TNEW_W'(1);
            end
         end
      end else begin : g_tnew_pass
         always_comb begin
            tnew_load = src.tnew;
         end
      end
   endgenerate

   // An exception already carried from further upstream belongs to an older
   // event than one raised in the stage just left, so it wins.
   always_comb begin
      exc_load = local_exc;
      if (src.exc != 5'd0) begin
         exc_load = src.exc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         instr_q   <= 32'd0;
         pc_q      <= RESET_PC;
         payload_q <= '0;
         a3_q      <= 5'd0;
         rfwr_q    <= 1'b0;
         tnew_q    <= '0;
         exc_q     <= 5'd0;
         bd_q      <= 1'b0;
      end else if (req) begin
         valid_q   <= 1'b0;
         instr_q   <= 32'd0;
         pc_q      <= TRAP_PC;
         payload_q <= '0;
         a3_q      <= 5'd0;
         rfwr_q    <= 1'b0;
         tnew_q    <= '0;
         exc_q     <= 5'd0;
         bd_q      <= 1'b0;
      end else if (flush) begin
         valid_q   <= 1'b0;
         instr_q   <= 32'd0;
         pc_q      <= src.pc;
         payload_q <= '0;
         a3_q      <= 5'd0;
         rfwr_q    <= 1'b0;
         tnew_q    <= '0;
         exc_q     <= 5'd0;
         bd_q      <= src.bd;
      end else if (!stall) begin
         // invalid slots are loaded as given; upstream already zeroes
         // rfwr/tnew for them
         valid_q   <= src.valid;
         instr_q   <= src.instr;
         pc_q      <= src.pc;
         payload_q <= src.payload;
         a3_q      <= src.a3;
         rfwr_q    <= src.rfwr;
         tnew_q    <= tnew_load;
         exc_q     <= exc_load;
         bd_q      <= src.bd;
      end
   end

   // Counts stalled edges regardless of flush; a trap edge is not a stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (stall && !req && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign dst.valid   = valid_q;
   assign dst.instr   = instr_q;
   assign dst.pc      = pc_q;
   assign dst.payload = payload_q;
   assign dst.a3      = a3_q;
   assign dst.rfwr    = rfwr_q;
   assign dst.tnew    = tnew_q;
   assign dst.exc     = exc_q;
   assign dst.bd      = bd_q;
   assign stall_cnt   = cnt_q;

endmodule
